seq_match_ctrl: RTL and testbench
=================================

Name: seq_match_ctrl

Overview:
Programmable frame controller for our serial Mealy-style sequence detection. It accepts a start command carrying a pattern, pattern length and frame length, then scans exactly that many valid serial bits. It raises a same-cycle (Mealy) match flag on every overlapping occurrence, counts matches, and signals completion. It sits between a command source and a serial bit stream and replaces hard-wired detector FSMs with one configurable controller.

Parameters:
PW, 4, maximum pattern width in bits (>=2)
CW, 8, frame-length and match-counter width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
start  input  1  command strobe, sampled only in IDLE
pat  input  PW  pattern; pat[pat_len-1] is the oldest (first-received) bit, pat[0] the newest
pat_len  input  $clog2(PW)+1  active pattern length, legal 1..PW
frame_len  input  CW  number of valid bits to scan in this frame
x  input  1  serial data bit
x_valid  input  1  x is valid this cycle
busy  output  1  high while in RUN
y  output  1  Mealy match flag, combinational from state/registers and x, x_valid
match_cnt  output  CW  matches found in the current or last frame
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; shift register, bit counter and match_cnt = 0; done=0; busy=0; y=0. Reset mid-frame aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, busy=0, y=0:
  - start=1 with frame_len!=0 and pat_len in 1..PW: latch pat, pat_len and frame_len; clear the shift register, bits_seen and match_cnt; go to RUN on the next edge.
  - start=1 with frame_len==0 or illegal pat_len: clear match_cnt; go to DONE (no scan).
  - start=0: stay; match_cnt holds the previous result.
- RUN, busy=1:
  - Cycle with x_valid=0: no state change, y=0.
  - Cycle with x_valid=1: window w = {sr[PW-2:0], x}.
    - y=1 iff (bits_seen+1 >= pat_len) and the low pat_len bits of w equal the low pat_len bits of the latched pat. This is the same cycle as the completing bit, with zero latency.
    - On the edge: sr<=w, bits_seen<=bits_seen+1, and match_cnt increments when y=1.
  - Matches may overlap. Matches never use bits from a previous frame, because sr and bits_seen are cleared at start.
  - The x_valid bit with bits_seen+1==frame_len is the last bit. It is still evaluated for y and counted. Next state is DONE.
  - start is ignored in RUN; there is no re-arm mid-frame.
- DONE: done=1 for exactly one cycle; busy=0, y=0; next state IDLE. A start present in the DONE cycle is ignored; start is only sampled in IDLE.
- Width rules:
  - match_cnt <= bits_seen <= frame_len <= 2^CW-1, so the counter cannot overflow. No saturation logic is needed.
  - bits_seen is CW bits wide.
  - pat bits above pat_len-1 are don't-care.
- Latency: done rises on the clock edge following the last valid bit, i.e. 1 cycle after the last bit's cycle. Total from an accepted start = 1 + (cycles until frame_len valid bits) + 1.
- Outputs busy, done and match_cnt are registered. y is the only combinational output.

Test Plan:
- Basic overlap: pat=4'b1011, pat_len=4, frame_len=8, x=1,0,1,1,0,1,1,0 with x_valid=1 continuously -> y=1 on the 4th and 7th bits only. match_cnt=2. done pulses 1 cycle after the 8th bit. busy falls with done.
- Short pattern: pat_len=2, pat=xx11, frame_len=5, x all 1 -> y=0 on bit 1 and y=1 on bits 2-5. match_cnt=4.
- Stalls: same stimulus as basic overlap, with x_valid=0 for 3 cycles between bits 3 and 4 -> y stays 0 during the gaps. Results are identical (match_cnt=2). done is delayed by 3 cycles.
- Degenerate config: start with frame_len=0, then separately with pat_len=0 -> DONE on the next edge. done=1 for one cycle; match_cnt=0; busy never asserts.
- Reset mid-frame: assert reset=0 asynchronously after bit 5 of the basic stream -> busy, y and match_cnt go to 0 immediately, without waiting for a clock edge. No done pulse. A new start after release runs a clean frame, with match_cnt=2 for the basic stream.
- start while busy/DONE: pulse start with a different config during RUN and in the DONE cycle -> ignored. The frame completes with the original pattern result. The controller returns to IDLE and waits for a fresh start.

Source files
------------

// File: rtl/seq_match_if.sv
// Command/serial-stream bundle for the programmable sequence-match controller.
// The master drives the command and the bit stream; the slave reports status and the match flag.
interface seq_match_if #(
    parameter int PW = 4,
    parameter int CW = 8
);
    localparam int LW = $clog2(PW) + 1;

    logic          start;
    logic [PW-1:0] pat;
    logic [LW-1:0] pat_len;
    logic [CW-1:0] frame_len;
    logic          x;
    logic          x_valid;
    logic          busy;
    logic          y;
    logic [CW-1:0] match_cnt;
    logic          done;

    modport master (
        output start, pat, pat_len, frame_len, x, x_valid,
        input  busy, y, match_cnt, done
    );

    modport slave (
        input  start, pat, pat_len, frame_len, x, x_valid,
        output busy, y, match_cnt, done
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// Frame-based overlapping sequence detector with a Mealy match flag and a match counter.
// state | meaning
// IDLE  | waiting for start; match_cnt holds the last frame result
// RUN   | scanning frame_len valid bits, y flags each completed match
// DONE  | one-cycle completion pulse, then back to IDLE
module seq_match_ctrl #(
    parameter int PW = 4,
    parameter int CW = 8
) (
    input logic         clk,
    input logic         reset,
    seq_match_if.slave  bus
);
    localparam int LW = $clog2(PW) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] frame_q, frame_d;
    logic [CW-1:0] bits_q, bits_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-2:0] sr_q, sr_d;

    logic [PW-1:0] win;
    logic [PW-1:0] mask;
    logic [CW:0]   seen_nx;
    logic          hit;
    logic          len_ok;
    logic          y_c;

    assign win     = {sr_q, bus.x};
    // A shift by PW leaves zero, so the inversion yields the full-width mask.
    assign mask    = ~({PW{1'b1}} << len_q);
    assign seen_nx = {1'b0, bits_q} + {{CW{1'b0}}, 1'b1};
    assign hit     = (seen_nx >= (CW+1)'(len_q)) && ((win & mask) == (pat_q & mask));
    assign len_ok  = (bus.pat_len != '0) && (bus.pat_len <= LW'(PW));
    assign y_c     = (state_q == RUN) && bus.x_valid && hit;

    assign bus.y         = y_c;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.match_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        frame_d = frame_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    if ((bus.frame_len != '0) && len_ok) begin
                        pat_d   = bus.pat;
                        len_d   = bus.pat_len;
                        frame_d = bus.frame_len;
                        sr_d    = '0;
                        bits_d  = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (bus.x_valid) begin
                    sr_d   = win[PW-2:0];
                    bits_d = seen_nx[CW-1:0];
                    if (y_c) cnt_d = cnt_q + 1'b1;
                    if (seen_nx == {1'b0, frame_q}) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            frame_q <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            frame_q <= frame_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: a pattern-search reference model predicts y per bit
// and the final match count; a monitor compares whenever the DUT presents a bit or done.
module tb_seq_match_ctrl;
    localparam int PW = 4;
    localparam int CW = 8;
    localparam int LW = $clog2(PW) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_match_if #(.PW(PW), .CW(CW)) bus ();
    seq_match_ctrl #(.PW(PW), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit exp_y[$];
    int exp_cnt[$];
    bit frame_bits[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a match ends at bit n when the last len received bits, newest first,
    // equal pat[0], pat[1], ... pat[len-1].
    task automatic predict(input logic [PW-1:0] p, input int len, input int flen);
        int cnt = 0;
        bit m;
        if (flen == 0 || len < 1 || len > PW) begin
            exp_cnt.push_back(0);
            return;
        end
        for (int n = 1; n <= flen; n++) begin
            m = (n >= len);
            for (int k = 0; k < len; k++)
                if (m && frame_bits[n-1-k] != p[k]) m = 1'b0;
            exp_y.push_back(m);
            cnt += int'(m);
        end
        exp_cnt.push_back(cnt);
    endtask

    initial begin : monitor
        bit e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.x_valid === 1'b1) begin
                if (exp_y.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL y_bit: got bit with no prediction, y=%0d expected none", bus.y);
                end else begin
                    e = exp_y.pop_front();
                    chk("y_bit", 32'(bus.y), 32'(e));
                end
            end else begin
                chk("y_quiet", 32'(bus.y), 0);
            end
            if (bus.done === 1'b1) begin
                if (exp_cnt.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected: got done=1 expected no pending frame");
                end else begin
                    chk("match_cnt", 32'(bus.match_cnt), 32'(exp_cnt.pop_front()));
                end
                chk("busy_at_done", 32'(bus.busy), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_cfg();
        bus.start     = 1'b1;
        bus.pat       = PW'($urandom);
        bus.pat_len   = LW'($urandom_range(1, PW));
        bus.frame_len = CW'($urandom_range(1, 20));
    endtask

    task automatic run_frame(input logic [PW-1:0] p, input int len, input int flen,
                             input int stall_pct, input int stall_at, input int stall_n,
                             input bit poke);
        int st;
        bus.pat       = p;
        bus.pat_len   = LW'(len);
        bus.frame_len = CW'(flen);
        predict(p, len, flen);
        bus.start = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.pat       = PW'($urandom);
        bus.pat_len   = LW'($urandom);
        bus.frame_len = CW'($urandom);
        if (flen == 0 || len < 1 || len > PW) begin
            chk("degen_done", 32'(bus.done), 1);
            chk("degen_busy", 32'(bus.busy), 0);
            tick();
            chk("degen_done_pulse", 32'(bus.done), 0);
            chk("degen_idle_busy", 32'(bus.busy), 0);
            return;
        end
        chk("run_busy", 32'(bus.busy), 1);
        for (int i = 0; i < flen; i++) begin
            st = (i == stall_at) ? stall_n : 0;
            while (st < 3 && $urandom_range(0, 99) < stall_pct) st++;
            for (int s = 0; s < st; s++) begin
                bus.x_valid = 1'b0;
                bus.x       = 1'($urandom);
                if (poke) poke_cfg();
                tick();
                bus.start = 1'b0;
            end
            bus.x       = frame_bits[i];
            bus.x_valid = 1'b1;
            if (poke && i == flen / 2) poke_cfg();
            tick();
            bus.start   = 1'b0;
            bus.x_valid = 1'b0;
        end
        chk("done_latency", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 0);
        if (poke) poke_cfg();
        tick();
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        tick();
        chk("idle_stays", 32'(bus.busy), 0);
    endtask

    initial begin : stim
        int len, flen;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.pat       = '0;
        bus.pat_len   = '0;
        bus.frame_len = '0;
        bus.x         = 1'b0;
        bus.x_valid   = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_cnt", 32'(bus.match_cnt), 0);
        tick();
        reset = 1'b1;
        tick();

        frame_bits = '{1, 0, 1, 1, 0, 1, 1, 0};
        run_frame(4'b1011, 4, 8, 0, -1, 0, 1'b0);
        chk("basic_cnt_hold", 32'(bus.match_cnt), 2);

        frame_bits = '{1, 1, 1, 1, 1};
        run_frame(4'b0111, 2, 5, 0, -1, 0, 1'b0);
        chk("short_cnt_hold", 32'(bus.match_cnt), 4);

        frame_bits = '{1, 0, 1, 1, 0, 1, 1, 0};
        run_frame(4'b1011, 4, 8, 0, 3, 3, 1'b0);

        run_frame(4'b1011, 4, 0, 0, -1, 0, 1'b0);
        chk("degen_flen_cnt", 32'(bus.match_cnt), 0);
        frame_bits = '{1, 0, 1, 1, 0, 1, 1, 0};
        run_frame(4'b1011, 4, 8, 0, -1, 0, 1'b0);
        run_frame(4'b1011, 0, 8, 0, -1, 0, 1'b0);
        chk("degen_len_cnt", 32'(bus.match_cnt), 0);

        // Reset in the middle of the basic stream, after bit 5.
        frame_bits = '{1, 0, 1, 1, 0, 1, 1, 0};
        bus.pat = 4'b1011; bus.pat_len = LW'(4); bus.frame_len = CW'(8);
        predict(4'b1011, 4, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.x = frame_bits[i]; bus.x_valid = 1'b1;
            tick();
        end
        bus.x = 1'b1;
        bus.x_valid = 1'b0;
        chk("pre_rst_cnt", 32'(bus.match_cnt), 1);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        #2;
        reset = 1'b0;
        repeat (3) void'(exp_y.pop_back());
        void'(exp_cnt.pop_back());
        #1;
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_cnt", 32'(bus.match_cnt), 0);
        chk("async_rst_y", 32'(bus.y), 0);
        chk("async_rst_done", 32'(bus.done), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("post_rst_done", 32'(bus.done), 0);
        run_frame(4'b1011, 4, 8, 0, -1, 0, 1'b0);
        chk("post_rst_cnt", 32'(bus.match_cnt), 2);

        run_frame(4'b1011, 4, 8, 30, -1, 0, 1'b1);

        for (int f = 0; f < 40; f++) begin
            len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, PW));
            flen = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            frame_bits.delete();
            for (int i = 0; i < flen; i++) frame_bits.push_back(1'($urandom));
            run_frame(PW'($urandom), len, flen, $urandom_range(0, 40), -1, 0, 1'($urandom));
        end

        repeat (3) tick();
        chk("y_queue_empty", 32'(exp_y.size()), 0);
        chk("cnt_queue_empty", 32'(exp_cnt.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
